// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Brief    : Radix-2 iterative RV32M-style multiply/divide unit with ALU flags.
//            Optional bypass of trivial operations via ALU_MULDIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] dout,
  output logic            zero_flag,
  output logic            sign_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_mop;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic                r_div0;

  // Operand conditioning at issue time
  logic            w_op1_signed, w_op2_signed, w_sgn1, w_sgn2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_neg, w_div0, w_early;
  logic [2*XLEN-1:0] w_load_acc;

  assign w_op1_signed = (op_code == 3'd1) || (op_code == 3'd2) ||
                        (op_code == 3'd4) || (op_code == 3'd6);
  assign w_op2_signed = (op_code == 3'd1) || (op_code == 3'd4) || (op_code == 3'd6);
  assign w_sgn1 = w_op1_signed & op1[XLEN-1];
  assign w_sgn2 = w_op2_signed & op2[XLEN-1];
  assign w_mag1 = w_sgn1 ? -op1 : op1;
  assign w_mag2 = w_sgn2 ? -op2 : op2;
  assign w_neg  = (op_code[2] & op_code[1]) ? w_sgn1 : (w_sgn1 ^ w_sgn2);
  assign w_div0 = op_code[2] & (op2 == '0);

`ifdef ALU_MULDIV_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf = op_code[2] & ~op_code[0] &
                 (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);
  assign w_early = w_div0 | w_ovf | (op1 == '0);
  // Preload the accumulator with what CALC would have produced for the bypassed case.
  assign w_load_acc = w_div0 ? {w_mag1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, w_mag1};
`else
  assign w_early    = 1'b0;
  assign w_load_acc = {{XLEN{1'b0}}, w_mag1};
`endif

  // One iteration: acc = {hi, lo}; multiply shifts right, divide shifts left.
  logic [XLEN:0]     w_madd;
  logic [XLEN:0]     w_rsh;
  logic [XLEN-1:0]   w_sub;
  logic              w_ge;
  logic [2*XLEN-1:0] w_step;

  assign w_madd = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mop : {XLEN{1'b0}})};
  assign w_rsh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_ge   = (w_rsh >= {1'b0, r_mop});
  assign w_sub  = w_rsh[XLEN-1:0] - r_mop;
  assign w_step = r_op[2] ? {(w_ge ? w_sub : w_rsh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge}
                          : {w_madd, r_acc[XLEN-1:1]};

  // Sign correction and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_div_raw;
  logic [XLEN-1:0]   w_res;

  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_div_raw = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
  assign w_res     = !r_op[2]               ? ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                                                    : w_prod[2*XLEN-1:XLEN]) :
                     (r_div0 && !r_op[1])   ? {XLEN{1'b1}} :
                     (r_neg ? -w_div_raw : w_div_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_mop     <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_div0    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dout      <= '0;
      zero_flag <= 1'b0;
      sign_out  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op_code;
            r_mop  <= w_mag2;
            r_neg  <= w_neg;
            r_div0 <= w_div0;
            r_acc  <= w_load_acc;
            r_cnt  <= C_CNT_LAST;
            if (w_early) begin
              r_state <= S_FIX;
            end else begin
              r_state <= S_CALC;
              busy    <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - C_CNT_ONE;
          if (r_cnt == '0) begin
            r_state <= S_FIX;
            busy    <= 1'b0;
          end
        end
        S_FIX: begin
          dout      <= w_res;
          zero_flag <= (w_res == '0);
          sign_out  <= w_res[XLEN-1];
          done      <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Brief    : Self-checking bench: vector table, randomized ops vs. arithmetic
//            model, protocol sequences, and an XLEN=8 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [2:0]  op_code;
  logic [31:0] op1, op2, dout;
  logic        busy, done, zero_flag, sign_out;

  logic        start8;
  logic [2:0]  op_code8;
  logic [7:0]  op1_8, op2_8, dout8;
  logic        busy8, done8, zero8, sign8;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .dout(dout), .zero_flag(zero_flag), .sign_out(sign_out)
  );

  alu_muldiv_seq #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_code(op_code8), .op1(op1_8), .op2(op2_8),
    .busy(busy8), .done(done8), .dout(dout8), .zero_flag(zero8), .sign_out(sign8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (op)
      3'd0: begin r = ua * ub; return r[31:0];  end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; r = sa / sb; return r[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] minv, input logic [31:0] ones);
`ifdef ALU_MULDIV_EARLY_OUT_EN
    return (op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == minv && b == ones) || a == 0;
`else
    return (op == 3'd7) && (a == minv) && (b == ones) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op_code = op; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; op_code = 3'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    int lat, bcnt;
    logic [31:0] exp;
    bit early;
    exp   = ref32(op, a, b);
    early = is_early(op, a, b, 32'h80000000, 32'hFFFFFFFF);
    run32(op, a, b, lat, bcnt);
    chk({name, "_dout"}, dout, exp);
    chk({name, "_zero"}, zero_flag, exp == 0);
    chk({name, "_sign"}, sign_out, exp[31]);
    chk({name, "_latency"}, lat, early ? 1 : 33);
    chk({name, "_busy_cycles"}, bcnt, early ? 0 : 32);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, done, 0);
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    @(negedge clk);
    start8 = 1'b1; op_code8 = op; op1_8 = a; op2_8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int lat, bcnt, extra;
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB};
    tbl[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000};
    tbl[3]  = '{3'd2, 32'hFFFFFFFF,   32'h00000002, 32'hFFFFFFFF};
    tbl[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD};
    tbl[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,        32'd14};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,        32'd2};
    tbl[8]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF};
    tbl[9]  = '{3'd6, 32'd5,          32'd0,        32'd5};
    tbl[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
    tbl[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000};
    tbl[12] = '{3'd4, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF};
    tbl[13] = '{3'd6, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9};
    tbl[14] = '{3'd3, 32'h80000000,   32'd2,        32'h00000001};
    tbl[15] = '{3'd5, 32'd0,          32'd5,        32'h00000000};

    rst_n = 1'b0; start = 1'b0; op_code = '0; op1 = '0; op2 = '0;
    start8 = 1'b0; op_code8 = '0; op1_8 = '0; op2_8 = '0;
    #22;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dout", dout, 0);
    chk("reset_zero", zero_flag, 0);
    chk("reset_sign", sign_out, 0);
    chk("reset8_dout", dout8, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("vec%0d_model", i), ref32(tbl[i].op, tbl[i].a, tbl[i].b), tbl[i].exp);
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b);
    end

    for (int i = 0; i < 150; i++) begin
      check_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
    end

    // Start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; op_code = 3'd0; op1 = 32'd7; op2 = 32'hFFFFFFFD;
    @(posedge clk); #1;
    start = 1'b0; op_code = 3'd5; op1 = 32'd1; op2 = 32'd1;
    lat = 0;
    while (!done && lat < 100) begin
      start = (lat == 10);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("ignore_dout", dout, 32'hFFFFFFEB);
    chk("ignore_latency", lat, 33);
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done) extra++; end
    chk("ignore_no_second_done", extra, 0);

    // Back-to-back: start held during done
    run32(3'd5, 32'd100, 32'd7, lat, bcnt);
    chk("b2b_first_dout", dout, 14);
    start = 1'b1; op_code = 3'd7; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_cleared", done, 0);
    chk("b2b_busy", busy, 1);
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("b2b_second_dout", dout, 2);
    chk("b2b_second_latency", lat, 33);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op_code = 3'd0; op1 = 32'h0000FFFF; op2 = 32'h00001234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_dout", dout, 0);
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done) extra++; end
    chk("rst_mid_no_done", extra, 0);

    // XLEN=8 instance
    run8(3'd0, 8'h0F, 8'h11, lat);
    chk("x8_mul_dout", dout8, 8'hFF);
    chk("x8_mul_sign", sign8, 1);
    chk("x8_mul_latency", lat, 9);
    run8(3'd4, 8'h80, 8'hFF, lat);
    chk("x8_div_ovf_dout", dout8, 8'h80);
`ifdef ALU_MULDIV_EARLY_OUT_EN
    chk("x8_div_ovf_latency", lat, 1);
`else
    chk("x8_div_ovf_latency", lat, 9);
`endif
    run8(3'd7, 8'd200, 8'd9, lat);
    chk("x8_remu_dout", dout8, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
